can_fault_confinement: RTL and testbench

Parametrised CAN fault-confinement unit. It is the single-clock successor to the strobe-clocked error control unit. It maintains the transmit and receive error counters (TEC/REC), runs an explicit error-active / error-passive / bus-off state machine with warning flag and state-change interrupt, records the last error code, and performs bus-off recovery (auto or host-requested) by counting 11-recessive-bit idle sequences. It sits between the bit-timing/protocol engines, which supply strobes, error flags and counter codes, and the host register file.

---
 rtl/can_fault_confinement_pkg.sv | 38 +++
 rtl/can_fault_confinement_if.sv | 44 ++++
 rtl/can_fault_confinement_recovery_counter.sv | 52 +++++
 rtl/can_fault_confinement.sv | 166 ++++++++++++++++
 tb/tb_can_fault_confinement.sv | 397 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/can_fault_confinement_pkg.sv
// Shared types and constants for the CAN fault-confinement unit.
package can_pkg;

    typedef enum logic [1:0] {
        ERR_ACTIVE  = 2'b00,
        ERR_PASSIVE = 2'b01,
        BUS_OFF     = 2'b10
    } err_state_t;

    // Counter operation codes carried on rx_code / tx_code
    localparam logic [1:0] CNT_HOLD = 2'b00;
    localparam logic [1:0] CNT_INC1 = 2'b01;
    localparam logic [1:0] CNT_INC8 = 2'b10;
    localparam logic [1:0] CNT_DEC1 = 2'b11;

    // Last-error codes; a larger code takes precedence
    localparam logic [2:0] LEC_NONE  = 3'd0;
    localparam logic [2:0] LEC_ACK   = 3'd1;
    localparam logic [2:0] LEC_BIT   = 3'd2;
    localparam logic [2:0] LEC_CRC   = 3'd3;
    localparam logic [2:0] LEC_FORM  = 3'd4;
    localparam logic [2:0] LEC_STUFF = 3'd5;

    // Highest-priority error code among the flags that are set
    function automatic logic [2:0] lec_encode(input logic stuff_e, input logic form_e,
                                              input logic crc_e, input logic bit_e,
                                              input logic ack_e);
        logic [2:0] code;
        code = LEC_NONE;
        if (stuff_e)     code = LEC_STUFF;
        else if (form_e) code = LEC_FORM;
        else if (crc_e)  code = LEC_CRC;
        else if (bit_e)  code = LEC_BIT;
        else if (ack_e)  code = LEC_ACK;
        return code;
    endfunction

endpackage

// File: rtl/can_fault_confinement_if.sv
// Signal bundle between the protocol engines / host and the fault-confinement unit.
// master: the side driving strobes, flags and host controls; slave: the unit itself.
interface can_fault_confinement_if #(
    parameter int CNT_W = 9
);
    logic             bit_en;
    logic             tx_en;
    logic             rx_bit;
    logic [1:0]       rx_code;
    logic [1:0]       tx_code;
    logic             stuff_err;
    logic             form_err;
    logic             crc_err;
    logic             bit_err;
    logic             ack_err;
    logic             auto_recover;
    logic             recover_req;
    logic             cnt_wr_en;
    logic [CNT_W-1:0] cnt_wr_tec;
    logic [CNT_W-1:0] cnt_wr_rec;
    logic             lec_clr;
    logic [CNT_W-1:0] tec;
    logic [CNT_W-1:0] rec;
    logic [1:0]       err_state;
    logic             warn;
    logic [2:0]       lec;
    logic             start_err_tx;
    logic             state_irq;
    logic             recovering;

    modport master (
        output bit_en, tx_en, rx_bit, rx_code, tx_code,
        output stuff_err, form_err, crc_err, bit_err, ack_err,
        output auto_recover, recover_req, cnt_wr_en, cnt_wr_tec, cnt_wr_rec, lec_clr,
        input  tec, rec, err_state, warn, lec, start_err_tx, state_irq, recovering
    );

    modport slave (
        input  bit_en, tx_en, rx_bit, rx_code, tx_code,
        input  stuff_err, form_err, crc_err, bit_err, ack_err,
        input  auto_recover, recover_req, cnt_wr_en, cnt_wr_tec, cnt_wr_rec, lec_clr,
        output tec, rec, err_state, warn, lec, start_err_tx, state_irq, recovering
    );
endinterface

// File: rtl/can_fault_confinement_recovery_counter.sv
// Bus-off recovery counter: counts runs of IDLE_BITS recessive bits and flags
// completion once RECOVERY_SEQS runs have been seen. Held cleared while not running.
module can_recovery_counter #(
    parameter int IDLE_BITS     = 11,
    parameter int RECOVERY_SEQS = 128
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic bit_en,
    input  logic rx_bit,
    output logic done
);
    localparam int BIT_W = $clog2(IDLE_BITS + 1);
    localparam int SEQ_W = $clog2(RECOVERY_SEQS + 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(IDLE_BITS - 1);
    localparam logic [SEQ_W-1:0] SEQ_DONE = SEQ_W'(RECOVERY_SEQS);

    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [SEQ_W-1:0] seq_cnt_q, seq_cnt_d;

    // Next-count logic; a dominant bit restarts only the current idle run
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        seq_cnt_d = seq_cnt_q;
        done      = run && (seq_cnt_q == SEQ_DONE);
        if (!run || done) begin
            bit_cnt_d = '0;
            seq_cnt_d = '0;
        end else if (bit_en) begin
            if (!rx_bit) begin
                bit_cnt_d = '0;
            end else if (bit_cnt_q == BIT_LAST) begin
                bit_cnt_d = '0;
                seq_cnt_d = seq_cnt_q + 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_q <= '0;
            seq_cnt_q <= '0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            seq_cnt_q <= seq_cnt_d;
        end
    end
endmodule

// File: rtl/can_fault_confinement.sv
// CAN fault confinement: TEC/REC maintenance, active/passive/bus-off state,
// warning and state-change interrupt, last error code, bus-off recovery.
module can_fault_confinement
    import can_pkg::*;
#(
    parameter int CNT_W         = 9,
    parameter int WARN_LIMIT    = 96,
    parameter int PASSIVE_LIMIT = 128,
    parameter int BUSOFF_LIMIT  = 256,
    parameter int REC_CLAMP     = 120,
    parameter int IDLE_BITS     = 11,
    parameter int RECOVERY_SEQS = 128
) (
    input logic                   clk,
    input logic                   rst,
    can_fault_confinement_if.slave bus
);
    if (BUSOFF_LIMIT > 2**CNT_W - 1) begin : g_limit_check
        $error("BUSOFF_LIMIT does not fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] WARN_V    = CNT_W'(WARN_LIMIT);
    localparam logic [CNT_W-1:0] PASSIVE_V = CNT_W'(PASSIVE_LIMIT);
    localparam logic [CNT_W-1:0] BUSOFF_V  = CNT_W'(BUSOFF_LIMIT);
    localparam logic [CNT_W-1:0] CLAMP_V   = CNT_W'(REC_CLAMP);
    localparam logic [CNT_W:0]   ONE_W     = (CNT_W+1)'(1);
    localparam logic [CNT_W:0]   EIGHT_W   = (CNT_W+1)'(8);

    err_state_t       state_q, state_d, prev_state_q;
    logic [CNT_W-1:0] tec_q, tec_d, rec_q, rec_d;
    logic [CNT_W-1:0] tec_op, rec_op;
    logic [CNT_W:0]   tec_sum, rec_sum;
    logic [2:0]       lec_q, lec_d;
    logic             warn_q, warn_d, prev_warn_q;
    logic             irq_q, irq_d;
    logic             recovering_q, recovering_d;
    logic             rec_done;
    logic             any_err;

    assign any_err = bus.stuff_err | bus.form_err | bus.crc_err | bus.bit_err | bus.ack_err;

    can_recovery_counter #(
        .IDLE_BITS    (IDLE_BITS),
        .RECOVERY_SEQS(RECOVERY_SEQS)
    ) u_recovery (
        .clk   (clk),
        .rst   (rst),
        .run   (recovering_q),
        .bit_en(bus.bit_en),
        .rx_bit(bus.rx_bit),
        .done  (rec_done)
    );

    // REC result of the requested op: saturate on increment, clamp back from passive on decrement
    always_comb begin
        rec_op  = rec_q;
        rec_sum = '0;
        case (bus.rx_code)
            CNT_INC1: rec_op = (rec_q == CNT_MAX) ? CNT_MAX : rec_q + 1'b1;
            CNT_INC8: begin
                rec_sum = {1'b0, rec_q} + EIGHT_W;
                rec_op  = rec_sum[CNT_W] ? CNT_MAX : rec_sum[CNT_W-1:0];
            end
            CNT_DEC1: begin
                if (rec_q >= PASSIVE_V)  rec_op = CLAMP_V;
                else if (rec_q != '0)    rec_op = rec_q - 1'b1;
            end
            default: ;
        endcase
    end

    // TEC result of the requested op: increments stop at the bus-off limit, decrement floors at 0
    always_comb begin
        tec_op  = tec_q;
        tec_sum = '0;
        case (bus.tx_code)
            CNT_INC1, CNT_INC8: begin
                tec_sum = {1'b0, tec_q} + ((bus.tx_code == CNT_INC8) ? EIGHT_W : ONE_W);
                tec_op  = (tec_sum >= {1'b0, BUSOFF_V}) ? BUSOFF_V : tec_sum[CNT_W-1:0];
            end
            CNT_DEC1: if (tec_q != '0) tec_op = tec_q - 1'b1;
            default: ;
        endcase
    end

    // Counter, state, recovery, warning, LEC and interrupt next-state logic
    always_comb begin
        tec_d        = tec_q;
        rec_d        = rec_q;
        state_d      = state_q;
        recovering_d = recovering_q;
        if (state_q == BUS_OFF) begin
            tec_d = BUSOFF_V;
            if (rec_done) begin
                tec_d        = '0;
                rec_d        = '0;
                state_d      = ERR_ACTIVE;
                recovering_d = 1'b0;
            end else if (bus.recover_req) begin
                recovering_d = 1'b1;
            end
        end else begin
            if (bus.cnt_wr_en) begin
                tec_d = bus.cnt_wr_tec;
                rec_d = bus.cnt_wr_rec;
            end else begin
                if (bus.bit_en) rec_d = rec_op;
                if (bus.tx_en)  tec_d = tec_op;
            end
            if (tec_d >= BUSOFF_V)
                state_d = BUS_OFF;
            else if (tec_d >= PASSIVE_V || rec_d >= PASSIVE_V)
                state_d = ERR_PASSIVE;
            else
                state_d = ERR_ACTIVE;
            recovering_d = (state_d == BUS_OFF) && bus.auto_recover;
        end

        warn_d = (tec_d >= WARN_V) || (rec_d >= WARN_V);

        lec_d = lec_q;
        if ((bus.bit_en || bus.tx_en) && any_err)
            lec_d = lec_encode(bus.stuff_err, bus.form_err, bus.crc_err, bus.bit_err, bus.ack_err);
        else if (bus.lec_clr)
            lec_d = LEC_NONE;

        // Pulse follows the visible change of err_state / rising warn by one cycle
        irq_d = (state_q != prev_state_q) || (warn_q && !prev_warn_q);
    end

    // State register bank
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ERR_ACTIVE;
            prev_state_q <= ERR_ACTIVE;
            tec_q        <= '0;
            rec_q        <= '0;
            lec_q        <= LEC_NONE;
            warn_q       <= 1'b0;
            prev_warn_q  <= 1'b0;
            irq_q        <= 1'b0;
            recovering_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_state_q <= state_q;
            tec_q        <= tec_d;
            rec_q        <= rec_d;
            lec_q        <= lec_d;
            warn_q       <= warn_d;
            prev_warn_q  <= warn_q;
            irq_q        <= irq_d;
            recovering_q <= recovering_d;
        end
    end

    assign bus.tec          = tec_q;
    assign bus.rec          = rec_q;
    assign bus.err_state    = state_q;
    assign bus.warn         = warn_q;
    assign bus.lec          = lec_q;
    assign bus.state_irq    = irq_q;
    assign bus.recovering   = recovering_q;
    assign bus.start_err_tx = any_err && (state_q != BUS_OFF);

endmodule

// File: tb/tb_can_fault_confinement.sv
// Directed self-checking bench for can_fault_confinement.
module tb_can_fault_confinement;
    import can_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    can_fault_confinement_if #(.CNT_W(9)) bus ();

    can_fault_confinement dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    // Stimulus helpers; all return at posedge + 1
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic tx_op(input logic [1:0] code);
        bus.tx_code = code; bus.tx_en = 1'b1;
        cycle();
        bus.tx_en = 1'b0; bus.tx_code = CNT_HOLD;
    endtask

    task automatic rx_op(input logic [1:0] code);
        bus.rx_code = code; bus.rx_bit = 1'b1; bus.bit_en = 1'b1;
        cycle();
        bus.bit_en = 1'b0; bus.rx_code = CNT_HOLD;
    endtask

    task automatic host_load(input logic [8:0] t, input logic [8:0] r);
        bus.cnt_wr_en = 1'b1; bus.cnt_wr_tec = t; bus.cnt_wr_rec = r;
        cycle();
        bus.cnt_wr_en = 1'b0;
    endtask

    task automatic send_bits(input int n, input logic val);
        for (int i = 0; i < n; i++) begin
            bus.rx_bit = val; bus.bit_en = 1'b1;
            cycle();
        end
        bus.bit_en = 1'b0; bus.rx_bit = 1'b1;
    endtask

    task automatic test_reset();
        bus.bit_en = 0; bus.tx_en = 0; bus.rx_bit = 1; bus.rx_code = CNT_HOLD; bus.tx_code = CNT_HOLD;
        bus.stuff_err = 0; bus.form_err = 0; bus.crc_err = 0; bus.bit_err = 0; bus.ack_err = 0;
        bus.auto_recover = 0; bus.recover_req = 0; bus.cnt_wr_en = 0;
        bus.cnt_wr_tec = '0; bus.cnt_wr_rec = '0; bus.lec_clr = 0;
        rst = 1'b1;
        cycle(); cycle();
        rst = 1'b0;
        checks++;
        if ({bus.tec, bus.rec, bus.err_state, bus.warn, bus.lec, bus.state_irq, bus.recovering} !== '0) begin
            failures++;
            $display("FAIL reset_outputs tec=%0d rec=%0d st=%0d warn=%0d lec=%0d irq=%0d recov=%0d exp all 0",
                     bus.tec, bus.rec, bus.err_state, bus.warn, bus.lec, bus.state_irq, bus.recovering);
        end
        checks++;
        if (bus.start_err_tx !== 1'b0) begin
            failures++; $display("FAIL reset_start_err_tx got=%0d exp=0", bus.start_err_tx);
        end
    endtask

    task automatic test_tec_ramp();
        for (int k = 1; k <= 16; k++) begin
            tx_op(CNT_INC8);
            checks++;
            if (bus.tec !== 9'(8 * k)) begin
                failures++; $display("FAIL ramp_tec k=%0d got=%0d exp=%0d", k, bus.tec, 8 * k);
            end
            checks++;
            if (bus.warn !== (k >= 12)) begin
                failures++; $display("FAIL ramp_warn k=%0d got=%0d exp=%0d", k, bus.warn, (k >= 12));
            end
            checks++;
            if (bus.err_state !== ((k >= 16) ? 2'b01 : 2'b00)) begin
                failures++; $display("FAIL ramp_state k=%0d got=%0d", k, bus.err_state);
            end
            cycle();
            checks++;
            if (bus.state_irq !== (k == 12 || k == 16)) begin
                failures++; $display("FAIL ramp_irq k=%0d got=%0d exp=%0d", k, bus.state_irq, (k == 12 || k == 16));
            end
            cycle();
            checks++;
            if (bus.state_irq !== 1'b0) begin
                failures++; $display("FAIL ramp_irq_width k=%0d got=%0d exp=0", k, bus.state_irq);
            end
        end
    endtask

    task automatic test_rec_ops();
        host_load(9'd0, 9'd130);
        checks++;
        if (bus.rec !== 9'd130 || bus.err_state !== 2'b01) begin
            failures++; $display("FAIL rec_load rec=%0d st=%0d exp 130/1", bus.rec, bus.err_state);
        end
        rx_op(CNT_DEC1);
        checks++;
        if (bus.rec !== 9'd120 || bus.err_state !== 2'b00) begin
            failures++; $display("FAIL rec_clamp rec=%0d st=%0d exp 120/0", bus.rec, bus.err_state);
        end
        cycle();
        checks++;
        if (bus.state_irq !== 1'b1) begin
            failures++; $display("FAIL rec_clamp_irq got=%0d exp=1", bus.state_irq);
        end
        rx_op(CNT_DEC1);
        checks++;
        if (bus.rec !== 9'd119) begin
            failures++; $display("FAIL rec_dec got=%0d exp=119", bus.rec);
        end
        host_load(9'd0, 9'd0);
        rx_op(CNT_DEC1);
        checks++;
        if (bus.rec !== 9'd0) begin
            failures++; $display("FAIL rec_dec_zero got=%0d exp=0", bus.rec);
        end
        rx_op(CNT_INC1);
        checks++;
        if (bus.rec !== 9'd1) begin
            failures++; $display("FAIL rec_inc1 got=%0d exp=1", bus.rec);
        end
        host_load(9'd0, 9'd508);
        rx_op(CNT_INC8);
        checks++;
        if (bus.rec !== 9'd511) begin
            failures++; $display("FAIL rec_sat8 got=%0d exp=511", bus.rec);
        end
        rx_op(CNT_INC1);
        checks++;
        if (bus.rec !== 9'd511) begin
            failures++; $display("FAIL rec_sat1 got=%0d exp=511", bus.rec);
        end
        rx_op(CNT_DEC1);
        checks++;
        if (bus.rec !== 9'd120) begin
            failures++; $display("FAIL rec_clamp_max got=%0d exp=120", bus.rec);
        end
        host_load(9'd0, 9'd0);
        cycle(); cycle();
    endtask

    task automatic test_bus_off();
        host_load(9'd250, 9'd0);
        tx_op(CNT_INC8);
        checks++;
        if (bus.tec !== 9'd256 || bus.err_state !== 2'b10 || bus.recovering !== 1'b0) begin
            failures++; $display("FAIL busoff_entry tec=%0d st=%0d recov=%0d exp 256/2/0",
                                 bus.tec, bus.err_state, bus.recovering);
        end
        tx_op(CNT_DEC1);
        checks++;
        if (bus.tec !== 9'd256) begin
            failures++; $display("FAIL busoff_tec_hold got=%0d exp=256", bus.tec);
        end
        host_load(9'd5, 9'd5);
        checks++;
        if (bus.tec !== 9'd256 || bus.rec !== 9'd0) begin
            failures++; $display("FAIL busoff_load_ignored tec=%0d rec=%0d exp 256/0", bus.tec, bus.rec);
        end
        rx_op(CNT_INC8);
        checks++;
        if (bus.rec !== 9'd0) begin
            failures++; $display("FAIL busoff_rx_ignored got=%0d exp=0", bus.rec);
        end
        bus.stuff_err = 1'b1;
        #1;
        checks++;
        if (bus.start_err_tx !== 1'b0) begin
            failures++; $display("FAIL busoff_start_err_tx got=%0d exp=0", bus.start_err_tx);
        end
        bus.stuff_err = 1'b0;
        send_bits(20, 1'b1);
        checks++;
        if (bus.recovering !== 1'b0 || bus.err_state !== 2'b10) begin
            failures++; $display("FAIL busoff_no_req recov=%0d st=%0d exp 0/2", bus.recovering, bus.err_state);
        end
        bus.recover_req = 1'b1;
        cycle();
        bus.recover_req = 1'b0;
        checks++;
        if (bus.recovering !== 1'b1) begin
            failures++; $display("FAIL recover_req got=%0d exp=1", bus.recovering);
        end
        send_bits(1407, 1'b1);
        checks++;
        if (bus.err_state !== 2'b10) begin
            failures++; $display("FAIL recovery_early_1407 st=%0d exp=2", bus.err_state);
        end
        send_bits(1, 1'b1);
        checks++;
        if (bus.err_state !== 2'b10 || bus.recovering !== 1'b1) begin
            failures++; $display("FAIL recovery_latency st=%0d recov=%0d exp 2/1", bus.err_state, bus.recovering);
        end
        cycle();
        checks++;
        if (bus.tec !== 9'd0 || bus.rec !== 9'd0 || bus.err_state !== 2'b00 || bus.recovering !== 1'b0) begin
            failures++; $display("FAIL recovery_done tec=%0d rec=%0d st=%0d recov=%0d exp 0/0/0/0",
                                 bus.tec, bus.rec, bus.err_state, bus.recovering);
        end
        cycle();
        checks++;
        if (bus.state_irq !== 1'b1) begin
            failures++; $display("FAIL recovery_irq got=%0d exp=1", bus.state_irq);
        end
        bus.recover_req = 1'b1;
        cycle();
        bus.recover_req = 1'b0;
        checks++;
        if (bus.recovering !== 1'b0) begin
            failures++; $display("FAIL recover_req_active_ignored got=%0d exp=0", bus.recovering);
        end
    endtask

    task automatic test_auto_recovery();
        bus.auto_recover = 1'b1;
        host_load(9'd250, 9'd100);
        tx_op(CNT_INC8);
        checks++;
        if (bus.err_state !== 2'b10 || bus.recovering !== 1'b1) begin
            failures++; $display("FAIL auto_start st=%0d recov=%0d exp 2/1", bus.err_state, bus.recovering);
        end
        send_bits(40, 1'b1);
        send_bits(1, 1'b0);
        send_bits(1374, 1'b1);
        checks++;
        if (bus.err_state !== 2'b10 || bus.recovering !== 1'b1) begin
            failures++; $display("FAIL auto_dominant_extension st=%0d recov=%0d exp 2/1", bus.err_state, bus.recovering);
        end
        send_bits(1, 1'b1);
        cycle();
        checks++;
        if (bus.tec !== 9'd0 || bus.rec !== 9'd0 || bus.err_state !== 2'b00 || bus.recovering !== 1'b0) begin
            failures++; $display("FAIL auto_done tec=%0d rec=%0d st=%0d recov=%0d exp 0/0/0/0",
                                 bus.tec, bus.rec, bus.err_state, bus.recovering);
        end
        bus.auto_recover = 1'b0;
        cycle(); cycle();
    endtask

    task automatic test_lec();
        bus.crc_err = 1'b1; bus.bit_err = 1'b1;
        #1;
        checks++;
        if (bus.start_err_tx !== 1'b1) begin
            failures++; $display("FAIL start_err_tx_flags got=%0d exp=1", bus.start_err_tx);
        end
        bus.bit_en = 1'b1;
        cycle();
        bus.bit_en = 1'b0; bus.crc_err = 1'b0; bus.bit_err = 1'b0;
        #1;
        checks++;
        if (bus.lec !== LEC_CRC) begin
            failures++; $display("FAIL lec_crc_bit got=%0d exp=3", bus.lec);
        end
        checks++;
        if (bus.start_err_tx !== 1'b0) begin
            failures++; $display("FAIL start_err_tx_idle got=%0d exp=0", bus.start_err_tx);
        end
        bus.stuff_err = 1'b1;
        cycle();
        bus.stuff_err = 1'b0;
        checks++;
        if (bus.lec !== LEC_CRC) begin
            failures++; $display("FAIL lec_no_strobe got=%0d exp=3", bus.lec);
        end
        bus.lec_clr = 1'b1;
        cycle();
        bus.lec_clr = 1'b0;
        checks++;
        if (bus.lec !== LEC_NONE) begin
            failures++; $display("FAIL lec_clr got=%0d exp=0", bus.lec);
        end
        bus.form_err = 1'b1; bus.tx_en = 1'b1; bus.lec_clr = 1'b1;
        cycle();
        bus.form_err = 1'b0; bus.tx_en = 1'b0; bus.lec_clr = 1'b0;
        checks++;
        if (bus.lec !== LEC_FORM) begin
            failures++; $display("FAIL lec_err_beats_clr got=%0d exp=4", bus.lec);
        end
        bus.stuff_err = 1; bus.form_err = 1; bus.crc_err = 1; bus.bit_err = 1; bus.ack_err = 1; bus.bit_en = 1;
        cycle();
        bus.stuff_err = 0; bus.form_err = 0; bus.crc_err = 0; bus.bit_err = 0; bus.ack_err = 0; bus.bit_en = 0;
        checks++;
        if (bus.lec !== LEC_STUFF) begin
            failures++; $display("FAIL lec_all_flags got=%0d exp=5", bus.lec);
        end
        bus.ack_err = 1'b1; bus.tx_en = 1'b1;
        cycle();
        bus.ack_err = 1'b0; bus.tx_en = 1'b0;
        checks++;
        if (bus.lec !== LEC_ACK) begin
            failures++; $display("FAIL lec_ack got=%0d exp=1", bus.lec);
        end
    endtask

    task automatic test_host_load();
        host_load(9'd200, 9'd0);
        checks++;
        if (bus.tec !== 9'd200 || bus.err_state !== 2'b01 || bus.warn !== 1'b1) begin
            failures++; $display("FAIL host_load_passive tec=%0d st=%0d warn=%0d exp 200/1/1",
                                 bus.tec, bus.err_state, bus.warn);
        end
        cycle();
        checks++;
        if (bus.state_irq !== 1'b1) begin
            failures++; $display("FAIL host_load_irq got=%0d exp=1", bus.state_irq);
        end
        bus.cnt_wr_en = 1; bus.cnt_wr_tec = 9'd100; bus.cnt_wr_rec = 9'd50;
        bus.tx_en = 1; bus.tx_code = CNT_INC8; bus.bit_en = 1; bus.rx_code = CNT_INC1;
        cycle();
        bus.cnt_wr_en = 0; bus.tx_en = 0; bus.bit_en = 0; bus.tx_code = CNT_HOLD; bus.rx_code = CNT_HOLD;
        checks++;
        if (bus.tec !== 9'd100 || bus.rec !== 9'd50 || bus.err_state !== 2'b00) begin
            failures++; $display("FAIL host_load_override tec=%0d rec=%0d st=%0d exp 100/50/0",
                                 bus.tec, bus.rec, bus.err_state);
        end
        bus.tx_en = 1; bus.tx_code = CNT_INC8; bus.bit_en = 1; bus.rx_code = CNT_INC1;
        cycle();
        bus.tx_en = 0; bus.bit_en = 0; bus.tx_code = CNT_HOLD; bus.rx_code = CNT_HOLD;
        checks++;
        if (bus.tec !== 9'd108 || bus.rec !== 9'd51) begin
            failures++; $display("FAIL simultaneous_strobes tec=%0d rec=%0d exp 108/51", bus.tec, bus.rec);
        end
        host_load(9'd0, 9'd0);
        tx_op(CNT_DEC1);
        checks++;
        if (bus.tec !== 9'd0) begin
            failures++; $display("FAIL tec_floor got=%0d exp=0", bus.tec);
        end
    endtask

    task automatic test_reset_mid_recovery();
        bus.auto_recover = 1'b1;
        host_load(9'd250, 9'd40);
        tx_op(CNT_INC8);
        bus.stuff_err = 1'b1;
        send_bits(100, 1'b1);
        bus.stuff_err = 1'b0;
        checks++;
        if (bus.recovering !== 1'b1 || bus.lec !== LEC_STUFF) begin
            failures++; $display("FAIL mid_recovery recov=%0d lec=%0d exp 1/5", bus.recovering, bus.lec);
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        checks++;
        if ({bus.tec, bus.rec, bus.err_state, bus.warn, bus.lec, bus.state_irq, bus.recovering} !== '0) begin
            failures++;
            $display("FAIL reset_mid_recovery tec=%0d rec=%0d st=%0d warn=%0d lec=%0d irq=%0d recov=%0d exp all 0",
                     bus.tec, bus.rec, bus.err_state, bus.warn, bus.lec, bus.state_irq, bus.recovering);
        end
        host_load(9'd250, 9'd0);
        tx_op(CNT_INC8);
        send_bits(1407, 1'b1);
        cycle();
        checks++;
        if (bus.err_state !== 2'b10) begin
            failures++; $display("FAIL recovery_restart_full st=%0d exp=2", bus.err_state);
        end
        send_bits(1, 1'b1);
        cycle();
        checks++;
        if (bus.err_state !== 2'b00 || bus.tec !== 9'd0) begin
            failures++; $display("FAIL recovery_restart_done st=%0d tec=%0d exp 0/0", bus.err_state, bus.tec);
        end
        bus.auto_recover = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_tec_ramp();
        test_rec_ops();
        test_bus_off();
        test_auto_recovery();
        test_lec();
        test_host_load();
        test_reset_mid_recovery();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
